// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_pkg
// Brief    : Shared state, rotation and push codes for the tank controller,
//            plus the saturating position helper.
// Revision : 1.0
// ============================================================================
package tank_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    RESPAWN = 2'd1,
    FROZEN  = 2'd2
  } tank_state_t;

  localparam logic [2:0] ROT_RIGHT = 3'b000;
  localparam logic [2:0] ROT_LEFT  = 3'b001;
  localparam logic [2:0] ROT_DOWN  = 3'b010;
  localparam logic [2:0] ROT_UP    = 3'b011;

  localparam logic [2:0] PUSH_LEFT  = 3'b000;
  localparam logic [2:0] PUSH_RIGHT = 3'b001;
  localparam logic [2:0] PUSH_UP    = 3'b010;
  localparam logic [2:0] PUSH_DOWN  = 3'b011;
  localparam logic [2:0] PUSH_NONE  = 3'b100;

  // Sum is widened to 12-bit signed so a step past either edge clamps instead of wrapping.
  function automatic logic [9:0] clamp_axis(
    input logic        [9:0]  pos,
    input logic        [9:0]  mv,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    logic signed [11:0] sum;
    sum = $signed({2'b00, pos}) + $signed({{2{mv[9]}}, mv});
    if (sum < lo)      clamp_axis = lo[9:0];
    else if (sum > hi) clamp_axis = hi[9:0];
    else               clamp_axis = sum[9:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module   : tank_ctrl_param_if
// Brief    : Keyboard/collision inputs and sprite outputs of one tank.
// Revision : 1.0
// ============================================================================
interface tank_ctrl_param_if #(
  parameter int N_OBST = 13
);
  import tank_pkg::*;

  logic [7:0]             keycode;
  logic                   game_over;
  logic                   shot_hit;
  logic [N_OBST-1:0][2:0] bounce_on;

  logic [9:0]  tankX;
  logic [9:0]  tankY;
  logic [9:0]  tankSx;
  logic [9:0]  tankSy;
  logic [2:0]  rotation;
  logic [9:0]  xmove;
  logic [9:0]  ymove;
  logic        field_on;
  logic        respawning;
  tank_state_t state;

  modport master (
    output keycode, game_over, shot_hit, bounce_on,
    input  tankX, tankY, tankSx, tankSy, rotation, xmove, ymove,
    input  field_on, respawning, state
  );

  modport slave (
    input  keycode, game_over, shot_hit, bounce_on,
    output tankX, tankY, tankSx, tankSy, rotation, xmove, ymove,
    output field_on, respawning, state
  );

endinterface
`default_nettype wire

// File: rtl/frame_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_down_counter
// Brief    : Loadable per-frame down counter that saturates at zero.
// Revision : 1.0
// ============================================================================
module frame_down_counter #(
  parameter int WIDTH = 8
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_clr,
  input  wire              i_load,
  input  wire              i_en,
  input  wire [WIDTH-1:0]  i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tank_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tank_ctrl_param
// Brief    : Per-player tank mover with clamped motion, timed shield and
//            respawn phase; advances once per video frame.
// Revision : 1.0
// ============================================================================
module tank_ctrl_param
  import tank_pkg::*;
#(
  parameter int         N_OBST          = 13,
  parameter int         X_MIN           = 0,
  parameter int         X_MAX           = 639,
  parameter int         Y_MIN           = 0,
  parameter int         Y_MAX           = 479,
  parameter int         SIZE_X          = 16,
  parameter int         SIZE_Y          = 16,
  parameter int         STEP            = 1,
  parameter int         SPAWN_X         = 525,
  parameter int         SPAWN_Y         = 240,
  parameter logic [2:0] SPAWN_ROT       = 3'b001,
  parameter logic [7:0] KEY_LEFT        = 8'h50,
  parameter logic [7:0] KEY_RIGHT       = 8'h4f,
  parameter logic [7:0] KEY_DOWN        = 8'h51,
  parameter logic [7:0] KEY_UP          = 8'h52,
  parameter logic [7:0] KEY_SHIELD      = 8'h13,
  parameter int         SHIELD_FRAMES   = 120,
  parameter int         COOLDOWN_FRAMES = 180,
  parameter int         RESPAWN_FRAMES  = 60
) (
  input  wire              frame_clk,
  input  wire              Reset,
  tank_ctrl_param_if.slave bus
);

  localparam int c_sh_w = $clog2(SHIELD_FRAMES + 1);
  localparam int c_cd_w = $clog2(COOLDOWN_FRAMES + 1);
  localparam int c_rs_w = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [c_sh_w-1:0] c_sh_load = c_sh_w'(SHIELD_FRAMES - 1);
  localparam logic [c_cd_w-1:0] c_cd_load = c_cd_w'(COOLDOWN_FRAMES - 1);
  localparam logic [c_rs_w-1:0] c_rs_load = c_rs_w'(RESPAWN_FRAMES - 1);

  localparam logic signed [11:0] c_x_lo = 12'(X_MIN + SIZE_X);
  localparam logic signed [11:0] c_x_hi = 12'(X_MAX - SIZE_X);
  localparam logic signed [11:0] c_y_lo = 12'(Y_MIN + SIZE_Y);
  localparam logic signed [11:0] c_y_hi = 12'(Y_MAX - SIZE_Y);

  localparam logic [9:0] c_step    = 10'(STEP);
  localparam logic [9:0] c_spawn_x = 10'(SPAWN_X);
  localparam logic [9:0] c_spawn_y = 10'(SPAWN_Y);

  tank_state_t r_state,  w_state_nxt;
  logic [9:0]  r_pos_x,  w_pos_x_nxt;
  logic [9:0]  r_pos_y,  w_pos_y_nxt;
  logic [2:0]  r_rot,    w_rot_nxt;
  logic [9:0]  r_xmove,  w_xmove_nxt;
  logic [9:0]  r_ymove,  w_ymove_nxt;
  logic        r_field_on,   w_field_on_nxt;
  logic        r_respawning, w_respawning_nxt;

  logic [9:0]  w_key_x, w_key_y, w_mv_x, w_mv_y;
  logic [2:0]  w_key_rot;
  logic        w_push_found;
  logic        w_arm;
  logic        w_clr;
  logic        w_sh_load, w_sh_en, w_sh_zero;
  logic        w_cd_load, w_cd_en, w_cd_zero;
  logic        w_rs_load, w_rs_en, w_rs_zero;

  frame_down_counter #(.WIDTH(c_sh_w)) u_shield_cnt (
    .clk(frame_clk), .rst(Reset), .i_clr(w_clr), .i_load(w_sh_load),
    .i_en(w_sh_en), .i_load_val(c_sh_load), .o_zero(w_sh_zero)
  );

  frame_down_counter #(.WIDTH(c_cd_w)) u_cooldown_cnt (
    .clk(frame_clk), .rst(Reset), .i_clr(w_clr), .i_load(w_cd_load),
    .i_en(w_cd_en), .i_load_val(c_cd_load), .o_zero(w_cd_zero)
  );

  frame_down_counter #(.WIDTH(c_rs_w)) u_respawn_cnt (
    .clk(frame_clk), .rst(Reset), .i_clr(w_clr), .i_load(w_rs_load),
    .i_en(w_rs_en), .i_load_val(c_rs_load), .o_zero(w_rs_zero)
  );

  // Key motion first, then the lowest-index active obstacle overrides one axis.
  always_comb begin
    w_key_x   = '0;
    w_key_y   = '0;
    w_key_rot = r_rot;
    if (bus.keycode == KEY_LEFT) begin
      w_key_x   = -c_step;
      w_key_rot = ROT_LEFT;
    end else if (bus.keycode == KEY_RIGHT) begin
      w_key_x   = c_step;
      w_key_rot = ROT_RIGHT;
    end else if (bus.keycode == KEY_DOWN) begin
      w_key_y   = c_step;
      w_key_rot = ROT_DOWN;
    end else if (bus.keycode == KEY_UP) begin
      w_key_y   = -c_step;
      w_key_rot = ROT_UP;
    end

    w_mv_x       = w_key_x;
    w_mv_y       = w_key_y;
    w_push_found = 1'b0;
    for (int i = 0; i < N_OBST; i++) begin
      if (!w_push_found && !bus.bounce_on[i][2]) begin
        w_push_found = 1'b1;
        case (bus.bounce_on[i])
          PUSH_LEFT:  w_mv_x = -c_step;
          PUSH_RIGHT: w_mv_x = c_step;
          PUSH_UP:    w_mv_y = -c_step;
          PUSH_DOWN:  w_mv_y = c_step;
          default:    ;
        endcase
      end
    end
  end

  assign w_arm = (r_state == PLAY) && (bus.keycode == KEY_SHIELD) &&
                 !r_field_on && w_cd_zero;

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_x_nxt      = r_pos_x;
    w_pos_y_nxt      = r_pos_y;
    w_rot_nxt        = r_rot;
    w_xmove_nxt      = '0;
    w_ymove_nxt      = '0;
    w_field_on_nxt   = r_field_on;
    w_respawning_nxt = r_respawning;
    w_clr            = 1'b0;
    w_sh_load        = 1'b0;
    w_sh_en          = 1'b0;
    w_cd_load        = 1'b0;
    w_cd_en          = 1'b0;
    w_rs_load        = 1'b0;
    w_rs_en          = 1'b0;

    if (bus.game_over) begin
      w_state_nxt      = FROZEN;
      w_pos_x_nxt      = c_spawn_x;
      w_pos_y_nxt      = c_spawn_y;
      w_rot_nxt        = SPAWN_ROT;
      w_field_on_nxt   = 1'b0;
      w_respawning_nxt = 1'b0;
      w_clr            = 1'b1;
    end else begin
      // Shield and cooldown timers run in both PLAY and RESPAWN.
      if (w_arm) begin
        w_field_on_nxt = 1'b1;
        w_sh_load      = 1'b1;
      end else if (r_field_on) begin
        if (w_sh_zero) begin
          w_field_on_nxt = 1'b0;
          w_cd_load      = 1'b1;
        end else begin
          w_sh_en = 1'b1;
        end
      end else begin
        w_cd_en = 1'b1;
      end

      case (r_state)
        PLAY: begin
          if (bus.shot_hit && !r_field_on && !w_arm) begin
            w_state_nxt      = RESPAWN;
            w_pos_x_nxt      = c_spawn_x;
            w_pos_y_nxt      = c_spawn_y;
            w_rot_nxt        = SPAWN_ROT;
            w_respawning_nxt = 1'b1;
            w_rs_load        = 1'b1;
          end else begin
            w_pos_x_nxt = clamp_axis(r_pos_x, w_mv_x, c_x_lo, c_x_hi);
            w_pos_y_nxt = clamp_axis(r_pos_y, w_mv_y, c_y_lo, c_y_hi);
            w_rot_nxt   = w_key_rot;
            w_xmove_nxt = w_mv_x;
            w_ymove_nxt = w_mv_y;
          end
        end
        RESPAWN: begin
          if (w_rs_zero) begin
            w_state_nxt      = PLAY;
            w_respawning_nxt = 1'b0;
          end else begin
            w_rs_en = 1'b1;
          end
        end
        FROZEN:  w_state_nxt = PLAY;
        default: w_state_nxt = PLAY;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state      <= PLAY;
      r_pos_x      <= c_spawn_x;
      r_pos_y      <= c_spawn_y;
      r_rot        <= SPAWN_ROT;
      r_xmove      <= '0;
      r_ymove      <= '0;
      r_field_on   <= 1'b0;
      r_respawning <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos_x      <= w_pos_x_nxt;
      r_pos_y      <= w_pos_y_nxt;
      r_rot        <= w_rot_nxt;
      r_xmove      <= w_xmove_nxt;
      r_ymove      <= w_ymove_nxt;
      r_field_on   <= w_field_on_nxt;
      r_respawning <= w_respawning_nxt;
    end
  end

  assign bus.tankX      = r_pos_x;
  assign bus.tankY      = r_pos_y;
  assign bus.tankSx     = 10'(SIZE_X);
  assign bus.tankSy     = 10'(SIZE_Y);
  assign bus.rotation   = r_rot;
  assign bus.xmove      = r_xmove;
  assign bus.ymove      = r_ymove;
  assign bus.field_on   = r_field_on;
  assign bus.respawning = r_respawning;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tank_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_ctrl_param
// Brief    : Vector table plus corner sequences for two tank configurations.
// Revision : 1.0
// ============================================================================
module tb_tank_ctrl_param;
  import tank_pkg::*;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rot;
    logic [9:0] xm;
    logic [9:0] ym;
    logic       fo;
    logic       rs;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    string       name;
    bit          sel;
    logic        rst;
    logic        go;
    logic        hit;
    logic [7:0]  key;
    logic [38:0] bnc;
    exp_t        e;
  } vec_t;

  typedef struct {
    string name;
    bit    sel;
    exp_t  e;
  } sb_t;

  localparam logic [38:0] NB = {13{3'b100}};

  logic frame_clk = 1'b0;
  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;

  vec_t vecs[$];
  sb_t  sb_q[$];

  always #5 frame_clk = ~frame_clk;

  tank_ctrl_param_if #(.N_OBST(13)) bus_a ();
  tank_ctrl_param_if #(.N_OBST(13)) bus_b ();

  tank_ctrl_param #(
    .STEP(1), .SHIELD_FRAMES(3), .COOLDOWN_FRAMES(2), .RESPAWN_FRAMES(4)
  ) dut_a (
    .frame_clk(frame_clk), .Reset(rst_a), .bus(bus_a)
  );

  tank_ctrl_param #(
    .STEP(4), .SPAWN_X(620)
  ) dut_b (
    .frame_clk(frame_clk), .Reset(rst_b), .bus(bus_b)
  );

  function automatic logic [38:0] set_push(input logic [38:0] b, input int idx, input logic [2:0] code);
    logic [38:0] r;
    r = b;
    r[idx*3 +: 3] = code;
    return r;
  endfunction

  task automatic add(input string n, input bit sel, input logic rst, input logic go, input logic hit,
                     input logic [7:0] key, input logic [38:0] bnc, input int x, input int y,
                     input logic [2:0] rot, input int xm, input int ym, input logic fo,
                     input logic rs, input logic [1:0] st);
    vec_t v;
    v.name = n; v.sel = sel; v.rst = rst; v.go = go; v.hit = hit; v.key = key; v.bnc = bnc;
    v.e.x  = 10'(x);  v.e.y  = 10'(y);  v.e.rot = rot;
    v.e.xm = 10'(xm); v.e.ym = 10'(ym); v.e.fo = fo; v.e.rs = rs; v.e.st = st;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit sel, input logic rst, input logic go, input logic hit,
                       input logic [7:0] key, input logic [38:0] bnc);
    rst_a = 1'b0; bus_a.game_over = 1'b0; bus_a.shot_hit = 1'b0; bus_a.keycode = 8'h00; bus_a.bounce_on = NB;
    rst_b = 1'b0; bus_b.game_over = 1'b0; bus_b.shot_hit = 1'b0; bus_b.keycode = 8'h00; bus_b.bounce_on = NB;
    if (!sel) begin
      rst_a = rst; bus_a.game_over = go; bus_a.shot_hit = hit; bus_a.keycode = key; bus_a.bounce_on = bnc;
    end else begin
      rst_b = rst; bus_b.game_over = go; bus_b.shot_hit = hit; bus_b.keycode = key; bus_b.bounce_on = bnc;
    end
  endtask

  function automatic exp_t sample(input bit sel);
    exp_t a;
    if (!sel) begin
      a.x = bus_a.tankX; a.y = bus_a.tankY; a.rot = bus_a.rotation; a.xm = bus_a.xmove;
      a.ym = bus_a.ymove; a.fo = bus_a.field_on; a.rs = bus_a.respawning; a.st = bus_a.state;
    end else begin
      a.x = bus_b.tankX; a.y = bus_b.tankY; a.rot = bus_b.rotation; a.xm = bus_b.xmove;
      a.ym = bus_b.ymove; a.fo = bus_b.field_on; a.rs = bus_b.respawning; a.st = bus_b.state;
    end
    return a;
  endfunction

  task automatic check_exp(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual x=%0d y=%0d rot=%b xm=%h ym=%h fo=%b rs=%b st=%0d | required x=%0d y=%0d rot=%b xm=%h ym=%h fo=%b rs=%b st=%0d",
               name, act.x, act.y, act.rot, act.xm, act.ym, act.fo, act.rs, act.st,
               req.x, req.y, req.rot, req.xm, req.ym, req.fo, req.rs, req.st);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [38:0] b_up;
    logic [38:0] b_down;
    logic [38:0] b_pair;
    sb_t         s;
    int          cnt;

    b_pair = set_push(set_push(NB, 3, 3'b000), 7, 3'b001);
    b_up   = set_push(NB, 0, 3'b010);
    b_down = set_push(set_push(NB, 5, 3'b101), 12, 3'b011);

    //   name            sel rst go hit key    bnc     x    y    rot    xm  ym fo rs st
    add("reset",          0, 1, 0, 0, 8'h4f, NB,     525, 240, 3'b001,  0,  0, 0, 0, PLAY);
    add("right1",         0, 0, 0, 0, 8'h4f, NB,     526, 240, 3'b000,  1,  0, 0, 0, PLAY);
    add("right2",         0, 0, 0, 0, 8'h4f, NB,     527, 240, 3'b000,  1,  0, 0, 0, PLAY);
    add("right3",         0, 0, 0, 0, 8'h4f, NB,     528, 240, 3'b000,  1,  0, 0, 0, PLAY);
    add("release",        0, 0, 0, 0, 8'h00, NB,     528, 240, 3'b000,  0,  0, 0, 0, PLAY);
    add("bounce_low_idx", 0, 0, 0, 0, 8'h52, b_pair, 527, 239, 3'b011, -1, -1, 0, 0, PLAY);
    add("down",           0, 0, 0, 0, 8'h51, NB,     527, 240, 3'b010,  0,  1, 0, 0, PLAY);
    add("left",           0, 0, 0, 0, 8'h50, NB,     526, 240, 3'b001, -1,  0, 0, 0, PLAY);
    add("hit",            0, 0, 0, 1, 8'h00, NB,     525, 240, 3'b001,  0,  0, 0, 1, RESPAWN);
    add("resp_hit_ign",   0, 0, 0, 1, 8'h4f, NB,     525, 240, 3'b001,  0,  0, 0, 1, RESPAWN);
    add("resp_key_ign",   0, 0, 0, 0, 8'h4f, NB,     525, 240, 3'b001,  0,  0, 0, 1, RESPAWN);
    add("resp_last",      0, 0, 0, 0, 8'h4f, NB,     525, 240, 3'b001,  0,  0, 0, 1, RESPAWN);
    add("resp_exit",      0, 0, 0, 0, 8'h4f, NB,     525, 240, 3'b001,  0,  0, 0, 0, PLAY);
    add("play_again",     0, 0, 0, 0, 8'h4f, NB,     526, 240, 3'b000,  1,  0, 0, 0, PLAY);
    add("shield_arm",     0, 0, 0, 0, 8'h13, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("shield_hit_ign", 0, 0, 0, 1, 8'h00, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("shield_f3",      0, 0, 0, 0, 8'h00, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("shield_off",     0, 0, 0, 0, 8'h00, NB,     526, 240, 3'b000,  0,  0, 0, 0, PLAY);
    add("cooldown_ign",   0, 0, 0, 0, 8'h13, NB,     526, 240, 3'b000,  0,  0, 0, 0, PLAY);
    add("rearm",          0, 0, 0, 0, 8'h13, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("hold_f2",        0, 0, 0, 0, 8'h13, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("hold_f3",        0, 0, 0, 0, 8'h13, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("hold_no_extend", 0, 0, 0, 0, 8'h13, NB,     526, 240, 3'b000,  0,  0, 0, 0, PLAY);
    add("cool_drain",     0, 0, 0, 0, 8'h00, NB,     526, 240, 3'b000,  0,  0, 0, 0, PLAY);
    add("arm_beats_hit",  0, 0, 0, 1, 8'h13, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("move_shielded1", 0, 0, 0, 0, 8'h4f, NB,     527, 240, 3'b000,  1,  0, 1, 0, PLAY);
    add("move_shielded2", 0, 0, 0, 0, 8'h4f, NB,     528, 240, 3'b000,  1,  0, 1, 0, PLAY);
    add("shield_off2",    0, 0, 0, 0, 8'h00, NB,     528, 240, 3'b000,  0,  0, 0, 0, PLAY);
    add("hit2",           0, 0, 0, 1, 8'h00, NB,     525, 240, 3'b001,  0,  0, 0, 1, RESPAWN);
    add("go_mid_resp",    0, 0, 1, 0, 8'h00, NB,     525, 240, 3'b001,  0,  0, 0, 0, FROZEN);
    add("frozen_hold",    0, 0, 1, 0, 8'h4f, NB,     525, 240, 3'b001,  0,  0, 0, 0, FROZEN);
    add("unfreeze_still", 0, 0, 0, 0, 8'h4f, NB,     525, 240, 3'b001,  0,  0, 0, 0, PLAY);
    add("unfreeze_move",  0, 0, 0, 0, 8'h4f, NB,     526, 240, 3'b000,  1,  0, 0, 0, PLAY);
    add("arm_after_go",   0, 0, 0, 0, 8'h13, NB,     526, 240, 3'b000,  0,  0, 1, 0, PLAY);
    add("go_shielded",    0, 0, 1, 0, 8'h00, NB,     525, 240, 3'b001,  0,  0, 0, 0, FROZEN);
    add("reset_beats_go", 0, 1, 1, 0, 8'h00, NB,     525, 240, 3'b001,  0,  0, 0, 0, PLAY);
    add("post_reset",     0, 0, 0, 0, 8'h00, NB,     525, 240, 3'b001,  0,  0, 0, 0, PLAY);
    add("b_reset",        1, 1, 0, 0, 8'h00, NB,     620, 240, 3'b001,  0,  0, 0, 0, PLAY);
    add("b_clamp1",       1, 0, 0, 0, 8'h4f, NB,     623, 240, 3'b000,  4,  0, 0, 0, PLAY);
    add("b_clamp2",       1, 0, 0, 0, 8'h4f, NB,     623, 240, 3'b000,  4,  0, 0, 0, PLAY);
    add("b_release",      1, 0, 0, 0, 8'h00, NB,     623, 240, 3'b000,  0,  0, 0, 0, PLAY);
    add("b_left4",        1, 0, 0, 0, 8'h50, NB,     619, 240, 3'b001, -4,  0, 0, 0, PLAY);
    add("b_push_up",      1, 0, 0, 0, 8'h00, b_up,   619, 236, 3'b001,  0, -4, 0, 0, PLAY);
    add("b_push_down",    1, 0, 0, 0, 8'h00, b_down, 619, 240, 3'b001,  0,  4, 0, 0, PLAY);

    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, NB);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].rst, vecs[i].go, vecs[i].hit, vecs[i].key, vecs[i].bnc);
      s.name = vecs[i].name;
      s.sel  = vecs[i].sel;
      s.e    = vecs[i].e;
      sb_q.push_back(s);
      tick();
      if (sb_q.size() == 0) begin
        check_val("scoreboard_empty", 0, 1);
      end else begin
        s = sb_q.pop_front();
        check_exp(s.name, sample(s.sel), s.e);
      end
    end

    check_val("size_x", int'(bus_a.tankSx), 16);
    check_val("size_y", int'(bus_b.tankSy), 16);

    // One-frame hit: respawning must stay high for exactly RESPAWN_FRAMES edges.
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00, NB);
    tick();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus_a.respawning) break;
      cnt++;
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, NB);
      tick();
    end
    check_val("respawn_len", cnt, 4);
    check_val("respawn_exit_state", int'(bus_a.state), int'(PLAY));

    for (int k = 0; k < 70; k++) begin
      drive(1, 1'b0, 1'b0, 1'b0, 8'h52, NB);
      tick();
    end
    check_val("clamp_ymin_y", int'(bus_b.tankY), 16);
    check_val("clamp_ymin_ymove", int'(bus_b.ymove), 'h3FC);

    for (int k = 0; k < 170; k++) begin
      drive(1, 1'b0, 1'b0, 1'b0, 8'h50, NB);
      tick();
    end
    check_val("clamp_xmin_x", int'(bus_b.tankX), 16);
    check_val("clamp_xmin_rot", int'(bus_b.rotation), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tank_ctrl_param.md
Name: tank_ctrl_param

Overview:
Parametrised per-player tank controller. It is the next generation of the player-2 tank mover: bounds, step, spawn point, key map and obstacle count are all parameters. It adds a timed shield with cooldown, a respawn/invulnerability phase after a hit, edge clamping instead of bounce, and stop-on-release motion. One instance per player sits between the keyboard decoder and the sprite/collision logic, and is updated once per frame.

Parameters:
N_OBST, 13, number of obstacle bounce inputs
X_MIN / X_MAX, 0 / 639, arena horizontal limits (pixels)
Y_MIN / Y_MAX, 0 / 479, arena vertical limits
SIZE_X / SIZE_Y, 16 / 16, tank half-extent; constant on size outputs
STEP, 1, pixels moved per frame (1..15)
SPAWN_X / SPAWN_Y / SPAWN_ROT, 525 / 240 / 3'b001, spawn position and facing
KEY_LEFT / KEY_RIGHT / KEY_DOWN / KEY_UP / KEY_SHIELD, 8'h50 / 8'h4f / 8'h51 / 8'h52 / 8'h13, keycodes
SHIELD_FRAMES, 120, shield duration in frames (>=1)
COOLDOWN_FRAMES, 180, frames after shield expiry before re-arm (>=1)
RESPAWN_FRAMES, 60, invulnerable frames after a hit (>=1)

Ports:
frame_clk  in  1  sole clock; one edge per video frame
Reset  in  1  synchronous, active-high reset
keycode  in  8  current keyboard code
game_over  in  1  either game-over screen active
shot_hit  in  1  enemy shell hit this tank this frame
bounce_on  in  N_OBST x 3  per-obstacle push code (tank_pkg)
tankX, tankY  out  10  centre position
tankSx, tankSy  out  10  SIZE_X, SIZE_Y
rotation  out  3  facing code
xmove, ymove  out  10  two's-complement motion applied this frame
field_on  out  1  shield active
respawning  out  1  high in RESPAWN state
state  out  2  tank_state_t

Behaviour:
- Everything is registered on posedge frame_clk. Priority per edge: Reset > game_over > (state-specific).
- Reset: state=PLAY; pos=(SPAWN_X,SPAWN_Y); rotation=SPAWN_ROT; xmove=ymove=0; field_on=0; shield, cooldown and respawn counters=0; respawning=0.
- game_over=1 in any state: state=FROZEN; pos=spawn; rotation=SPAWN_ROT; motion=0; field_on=0; all counters cleared.
- FROZEN: hold. The first edge with game_over=0 goes to PLAY; no movement occurs on that edge.
- PLAY, movement:
  - KEY_LEFT: motion (-STEP,0), rot=001.
  - KEY_RIGHT: motion (+STEP,0), rot=000.
  - KEY_DOWN: motion (0,+STEP), rot=010.
  - KEY_UP: motion (0,-STEP), rot=011.
  - Any other code: motion (0,0), rotation held.
- Obstacle override: the lowest index i with bounce_on[i] in {000,001,010,011} replaces one motion axis.
  - 000: x=-STEP
  - 001: x=+STEP
  - 010: y=-STEP
  - 011: y=+STEP
  - Codes 1xx mean no push.
- Position: new pos = pos + final motion, computed in the same edge (zero latency). The sum is evaluated as 12-bit signed, then clamped to [X_MIN+SIZE_X, X_MAX-SIZE_X] and [Y_MIN+SIZE_Y, Y_MAX-SIZE_Y]. There is no wrap. xmove/ymove report the pre-clamp final motion.
- Shield:
  - Arms when keycode==KEY_SHIELD in PLAY, field_on=0 and cooldown=0: field_on=1, shield_cnt=SHIELD_FRAMES-1.
  - While on, shield_cnt decrements each frame. At the edge where it is 0: field_on=0, cooldown=COOLDOWN_FRAMES-1.
  - Cooldown decrements to 0, then the shield is re-armable.
  - Holding the key does not retrigger or extend the shield.
  - Shield timers keep running in RESPAWN.
- Hit: shot_hit in PLAY with field_on=0 → state=RESPAWN, pos=spawn, rotation=SPAWN_ROT, motion=0, resp_cnt=RESPAWN_FRAMES-1, respawning=1. With field_on=1 the hit is ignored. A hit on the same edge as shield arming is ignored (shield wins).
- RESPAWN: keys and bounce ignored; pos held; shot_hit ignored. resp_cnt decrements; at the edge where it is 0, state goes to PLAY and respawning=0.
- Counter widths: $clog2(max+1). Counters never underflow.

Decomposition:
- tank_pkg: tank_state_t {PLAY=0, RESPAWN=1, FROZEN=2}; rotation codes ROT_RIGHT/LEFT/DOWN/UP; bounce codes PUSH_LEFT/RIGHT/UP/DOWN/NONE.
- Sub-module frame_down_counter (parametric width): load, enable, zero flag. Instantiated three times for shield, cooldown and respawn.

Test Plan:
- Reset with keycode=8'h4f → tankX=525, tankY=240, rotation=001, field_on=0, state=PLAY. Then 3 edges of 8'h4f → tankX=528, xmove=1, rotation=000.
- STEP=4, X start 620, 8'h4f for 2 frames → tankX=623 (clamped) and stays 623. Release key → xmove=0.
- bounce_on[3]=000, bounce_on[7]=001, keycode=8'h52 → xmove=-1, ymove=-1; index 3 wins.
- RESPAWN_FRAMES=4: shot_hit for 1 frame mid-arena → pos=(525,240) and respawning=1 for exactly 4 edges. A shot_hit during that window has no effect; then state=PLAY.
- SHIELD_FRAMES=3, COOLDOWN_FRAMES=2: press 8'h13 → field_on high 3 frames. A shot_hit in frame 2 is ignored. A re-press during the 2 cooldown frames is ignored; a press on the next frame re-arms.
- game_over asserted mid-RESPAWN with shield active → FROZEN, field_on=0, pos=spawn. Deassert → PLAY, no motion that edge. Reset asserted together with game_over → state=PLAY.
